// File: rtl/mem_responder.sv
// Memory-side bus target: word-addressed RAM plus a four-register MMIO block
// (LED, free-running COUNT, timer COMPARE, sticky STATUS/IRQ).
module mem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [15:0] MMIO_BASE   = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_mem_wrdata,
  output logic [15:0] o_mem_rddata,
  output logic        o_rddata_valid,
  output logic [15:0] o_leds,
  output logic        o_irq,
  output logic        o_bus_err
);

  // Handshake: there is no ready; every edge with i_mem_rd/i_mem_wr high is an
  // accepted request, and a read answers with o_rddata_valid high for exactly
  // the one cycle following its sampling edge (fixed latency 1, no stalls).

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [15:0] RAM_WORDS = 16'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    REG_LED     = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } mmio_reg_e;

  logic [15:0] mem [DEPTH_WORDS];

  logic [14:0] word_idx;
  logic [AW-1:0] ram_idx;
  logic        ram_hit;
  logic        mmio_hit;
  mmio_reg_e   reg_sel;
  logic        wr_led, wr_count, wr_compare, wr_status;
  logic        timer_match;
  logic [15:0] ram_rd_word;
  logic [15:0] rd_word;

  logic [15:0] rddata_d, rddata_q;
  logic        valid_d, valid_q;
  logic [15:0] leds_d, leds_q;
  logic [15:0] count_d, count_q;
  logic [15:0] compare_d, compare_q;
  logic        status_d, status_q;
  logic        bus_err_d, bus_err_q;

  assign word_idx    = i_mem_addr[15:1];
  assign ram_idx     = word_idx[AW-1:0];
  assign ram_hit     = ({1'b0, word_idx} < RAM_WORDS);
  assign mmio_hit    = !ram_hit && (i_mem_addr[15:3] == MMIO_BASE[15:3]);
  assign reg_sel     = mmio_reg_e'(i_mem_addr[2:1]);
  assign ram_rd_word = mem[ram_idx];

  assign wr_led     = i_mem_wr && mmio_hit && (reg_sel == REG_LED);
  assign wr_count   = i_mem_wr && mmio_hit && (reg_sel == REG_COUNT);
  assign wr_compare = i_mem_wr && mmio_hit && (reg_sel == REG_COMPARE);
  assign wr_status  = i_mem_wr && mmio_hit && (reg_sel == REG_STATUS);

  // Match compares the pre-increment count against the pre-write compare.
  assign timer_match = (compare_q != 16'h0000) && (count_q == compare_q);

  // Read mux sees only current (pre-write) state, giving read-before-write.
  always_comb begin
    rd_word = 16'h0000;
    if (ram_hit) begin
      rd_word = ram_rd_word;
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_LED:     rd_word = leds_q;
        REG_COUNT:   rd_word = count_q;
        REG_COMPARE: rd_word = compare_q;
        REG_STATUS:  rd_word = {15'h0000, status_q};
        default:     rd_word = 16'h0000;
      endcase
    end
  end

  always_comb begin
    rddata_d  = rddata_q;
    valid_d   = i_mem_rd;
    leds_d    = leds_q;
    count_d   = count_q + 16'd1;
    compare_d = compare_q;
    status_d  = status_q;
    bus_err_d = (i_mem_rd || i_mem_wr) && !ram_hit && !mmio_hit;

    if (i_mem_rd)   rddata_d  = rd_word;
    if (wr_led)     leds_d    = i_mem_wrdata;
    if (wr_count)   count_d   = i_mem_wrdata;
    if (wr_compare) compare_d = i_mem_wrdata;
    if (wr_status && i_mem_wrdata[0]) status_d = 1'b0;
    // A match on the same edge as a clear must win.
    if (timer_match) status_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rddata_q  <= 16'h0000;
      valid_q   <= 1'b0;
      leds_q    <= 16'h0000;
      count_q   <= 16'h0000;
      compare_q <= 16'h0000;
      status_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      rddata_q  <= rddata_d;
      valid_q   <= valid_d;
      leds_q    <= leds_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      bus_err_q <= bus_err_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_mem_wr && ram_hit) mem[ram_idx] <= i_mem_wrdata;
  end

  assign o_mem_rddata   = rddata_q;
  assign o_rddata_valid = valid_q;
  assign o_leds         = leds_q;
  assign o_irq          = status_q;
  assign o_bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: driver tasks push per-cycle expectations,
// a monitor pops and compares responses independently of the stimulus.
module tb_mem_responder;

  localparam logic [15:0] A_LED   = 16'hF000;
  localparam logic [15:0] A_COUNT = 16'hF002;
  localparam logic [15:0] A_CMP   = 16'hF004;
  localparam logic [15:0] A_STAT  = 16'hF006;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr = 16'h0000;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [15:0] mem_wrdata = 16'h0000;
  logic [15:0] mem_rddata;
  logic        rddata_valid;
  logic [15:0] leds;
  logic        irq;
  logic        bus_err;

  logic [15:0] exp_q[$];
  logic        exp_v_q[$];
  logic        exp_err_q[$];

  int vectors = 0;
  int miscompares = 0;

  mem_responder #(.DEPTH_WORDS(4096), .MMIO_BASE(16'hF000)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_mem_addr     (mem_addr),
    .i_mem_rd       (mem_rd),
    .i_mem_wr       (mem_wr),
    .i_mem_wrdata   (mem_wrdata),
    .o_mem_rddata   (mem_rddata),
    .o_rddata_valid (rddata_valid),
    .o_leds         (leds),
    .o_irq          (irq),
    .o_bus_err      (bus_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one request at a negedge, queue its expectations, return at next negedge
  task automatic bus(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] data, input logic [15:0] exp_rd, input logic exp_err);
    mem_rd     = rd;
    mem_wr     = wr;
    mem_addr   = addr;
    mem_wrdata = data;
    if (rd) exp_q.push_back(exp_rd);
    exp_v_q.push_back(rd);
    exp_err_q.push_back(exp_err);
    @(negedge clk);
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    bus(1'b0, 1'b1, addr, data, 16'h0000, 1'b0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp);
    bus(1'b1, 1'b0, addr, 16'h0000, exp, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
  endtask

  // Monitor / scoreboard
  initial begin
    logic        ev;
    logic        ee;
    logic [15:0] ed;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        ev = (exp_v_q.size() != 0) ? exp_v_q.pop_front() : 1'b0;
        ee = (exp_err_q.size() != 0) ? exp_err_q.pop_front() : 1'b0;
        check("rddata_valid", {15'h0000, rddata_valid}, {15'h0000, ev});
        check("bus_err", {15'h0000, bus_err}, {15'h0000, ee});
        if (ev) begin
          ed = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hXXXX;
          if (rddata_valid) check("rddata", mem_rddata, ed);
        end
      end
    end
  end

  // Stimulus
  initial begin
    repeat (2) @(negedge clk);
    check("reset_rddata", mem_rddata, 16'h0000);
    check("reset_valid", {15'h0000, rddata_valid}, 16'h0000);
    check("reset_leds", leds, 16'h0000);
    check("reset_irq", {15'h0000, irq}, 16'h0000);
    check("reset_bus_err", {15'h0000, bus_err}, 16'h0000);
    reset = 1'b0;

    // Timer: COUNT pre-increment value at the k-th edge after release is k-1
    wr(A_CMP, 16'h0005);
    idle(4);
    check("irq_before_match", {15'h0000, irq}, 16'h0000);
    idle(1);
    check("irq_on_match", {15'h0000, irq}, 16'h0001);
    wr(A_STAT, 16'h0001);
    check("irq_cleared", {15'h0000, irq}, 16'h0000);
    wr(A_COUNT, 16'h0004);
    idle(1);
    check("irq_before_rematch", {15'h0000, irq}, 16'h0000);
    wr(A_STAT, 16'h0001);
    check("irq_set_wins_clear", {15'h0000, irq}, 16'h0001);
    bus(1'b1, 1'b1, A_STAT, 16'h0001, 16'h0001, 1'b0);
    check("irq_cleared_rdwr", {15'h0000, irq}, 16'h0000);
    wr(A_CMP, 16'h0000);

    // RAM write/read, bit 0 ignored, read-before-write
    wr(16'h0010, 16'hBEEF);
    rd(16'h0010, 16'hBEEF);
    rd(16'h0011, 16'hBEEF);
    wr(16'h0020, 16'h1111);
    bus(1'b1, 1'b1, 16'h0020, 16'h2222, 16'h1111, 1'b0);
    rd(16'h0020, 16'h2222);
    wr(16'h1FFE, 16'hCAFE);
    rd(16'h1FFF, 16'hCAFE);

    // COUNT load and wrap
    wr(A_COUNT, 16'hFFFE);
    rd(A_COUNT, 16'hFFFE);
    rd(A_COUNT, 16'hFFFF);
    rd(A_COUNT, 16'h0000);

    // Unmapped accesses and LED register
    bus(1'b1, 1'b0, 16'hF008, 16'h0000, 16'h0000, 1'b1);
    bus(1'b0, 1'b1, 16'h9000, 16'h1234, 16'h0000, 1'b1);
    idle(1);
    bus(1'b1, 1'b1, 16'h2000, 16'h5555, 16'h0000, 1'b1);
    check("leds_after_unmapped", leds, 16'h0000);
    wr(A_LED, 16'h00A5);
    check("leds_written", leds, 16'h00A5);
    rd(A_LED, 16'h00A5);
    idle(1);
    check("rddata_hold", mem_rddata, 16'h00A5);

    // Reset while a read response is on the bus
    wr(16'h0100, 16'h5A5A);
    mem_rd   = 1'b1;
    mem_addr = 16'h0100;
    exp_q.push_back(16'h5A5A);
    exp_v_q.push_back(1'b1);
    exp_err_q.push_back(1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_valid", {15'h0000, rddata_valid}, 16'h0000);
    check("async_rst_rddata", mem_rddata, 16'h0000);
    check("async_rst_leds", leds, 16'h0000);
    check("async_rst_irq", {15'h0000, irq}, 16'h0000);
    mem_rd = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(16'h0100, 16'h5A5A);
    idle(2);

    check("pending_responses", 16'(exp_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
